// File: rtl/phy_tx_serializer.sv
// phy_tx_serializer: two-lane byte-to-bit serializer feeding the phy_rx link.
// Each lane shifts one byte out MSB first, one bit per clk_8f. After reset or
// enable, a preamble of SYNC_COMMAS comma bytes goes out on both lanes so the
// receiver can lock. After that, invalid slots carry COMMA.
// Optional build macro: PERIODIC_COMMA_EN forces a comma on both lanes every
// COMMA_PERIOD-th byte slot in ACTIVE, and no data is sampled for that slot.
//
// Handshake: ready is high for exactly one cycle before a data load edge. The
// bytes on data_in_x/valid_in_x are captured at that edge and ignored at all
// other times. There is no backpressure: a lane with valid_in_x low at that
// edge sends COMMA for the slot.
module phy_tx_serializer #(
  parameter int          SYNC_COMMAS  = 4,
  parameter logic [7:0]  COMMA        = 8'hBC,
  parameter int          COMMA_PERIOD = 16
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic [7:0] data_in_0,
  input  logic       valid_in_0,
  input  logic [7:0] data_in_1,
  input  logic       valid_in_1,
  output logic       ready,
  output logic       out_0,
  output logic       out_1,
  output logic       tx_active,
  output logic       dbg_state
);

  localparam int CW = (SYNC_COMMAS > 0) ? $clog2(SYNC_COMMAS + 1) : 1;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   comma_cnt_q, comma_cnt_d;
  logic            started_q, started_d;
  logic [7:0]      sh0_q, sh0_d;
  logic [7:0]      sh1_q, sh1_d;
  logic            load;
  logic            sync_done;
  logic            force_comma;

  if (COMMA_PERIOD < 1) begin : g_period_check
    $error("COMMA_PERIOD must be at least 1");
  end

`ifdef PERIODIC_COMMA_EN
  localparam int SW = (COMMA_PERIOD > 1) ? $clog2(COMMA_PERIOD) : 1;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;

  // The slot about to be loaded is a forced comma when the count reaches the period.
  assign force_comma = (slot_cnt_q == SW'(COMMA_PERIOD - 1));

  // Slot counter: counts data-phase load slots, cleared whenever SYNC is re-entered.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) slot_cnt_q <= '0;
    else          slot_cnt_q <= slot_cnt_d;
  end
`else
  assign force_comma = 1'b0;
`endif

  assign sync_done = (comma_cnt_q == CW'(SYNC_COMMAS));
  assign load      = enable & (~started_q | (bit_cnt_q == 3'd7));

  // Outputs come straight from flops, apart from ready, which is gated by enable.
  assign out_0     = sh0_q[7];
  assign out_1     = sh1_q[7];
  assign tx_active = (state_q == ACTIVE);
  assign dbg_state = state_q;
  assign ready     = enable & (bit_cnt_q == 3'd7) &
                     ((state_q == ACTIVE) | sync_done) & ~force_comma;

  // State register for the FSM, counters and both lane shift registers.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= SYNC;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      started_q   <= 1'b0;
      sh0_q       <= '0;
      sh1_q       <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      started_q   <= started_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
    end
  end

  // Next-state logic: disable clears everything, load edges pick the next byte,
  // other edges shift.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    started_d   = started_q;
    sh0_d       = sh0_q;
    sh1_d       = sh1_q;
`ifdef PERIODIC_COMMA_EN
    slot_cnt_d  = slot_cnt_q;
`endif
    if (!enable) begin
      // A disabled edge truncates the byte in flight and rearms the preamble.
      state_d     = SYNC;
      bit_cnt_d   = '0;
      comma_cnt_d = '0;
      started_d   = 1'b0;
      sh0_d       = '0;
      sh1_d       = '0;
`ifdef PERIODIC_COMMA_EN
      slot_cnt_d  = '0;
`endif
    end else if (load) begin
      bit_cnt_d = '0;
      started_d = 1'b1;
      if ((state_q == SYNC) && !sync_done) begin
        sh0_d       = COMMA;
        sh1_d       = COMMA;
        comma_cnt_d = comma_cnt_q + CW'(1);
      end else begin
        // The final preamble slot hands over to data in the same edge.
        state_d = ACTIVE;
        sh0_d   = (valid_in_0 && !force_comma) ? data_in_0 : COMMA;
        sh1_d   = (valid_in_1 && !force_comma) ? data_in_1 : COMMA;
`ifdef PERIODIC_COMMA_EN
        slot_cnt_d = force_comma ? '0 : slot_cnt_q + SW'(1);
`endif
      end
    end else begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      sh0_d     = {sh0_q[6:0], 1'b0};
      sh1_d     = {sh1_q[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Bench for phy_tx_serializer: directed link bring-up, disable and reset cases,
// then randomized traffic. A stream-level model predicts every output cycle.
module tb_phy_tx_serializer;

  localparam int         SYNC_COMMAS  = 4;
  localparam logic [7:0] COMMA        = 8'hBC;
  localparam int         COMMA_PERIOD = 16;
  localparam int         PRE          = 8 * SYNC_COMMAS;

  logic       clk_8f     = 1'b0;
  logic       reset_L    = 1'b0;
  logic       enable     = 1'b0;
  logic [7:0] data_in_0  = 8'h00;
  logic       valid_in_0 = 1'b0;
  logic [7:0] data_in_1  = 8'h00;
  logic       valid_in_1 = 1'b0;
  logic       ready, out_0, out_1, tx_active, dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_8f = ~clk_8f;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  phy_tx_serializer #(
    .SYNC_COMMAS (SYNC_COMMAS),
    .COMMA       (COMMA),
    .COMMA_PERIOD(COMMA_PERIOD)
  ) dut (
    .clk_8f    (clk_8f),
    .reset_L   (reset_L),
    .enable    (enable),
    .data_in_0 (data_in_0),
    .valid_in_0(valid_in_0),
    .data_in_1 (data_in_1),
    .valid_in_1(valid_in_1),
    .ready     (ready),
    .out_0     (out_0),
    .out_1     (out_1),
    .tx_active (tx_active),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // k counts enabled edges since the link was (re)started. Edges 1..PRE carry
  // the comma preamble; after that every 8 edges form one byte slot, whose
  // byte pair is captured at the slot's first edge into exp_q.
  int          k = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cur = 16'h0000;
  bit          chk_en = 1'b0;

  function automatic bit slot_forced(input int j);
    bit f;
    f = 1'b0;
`ifdef PERIODIC_COMMA_EN
    f = (((j + 1) % COMMA_PERIOD) == 0);
`endif
    return f | (j < 0);
  endfunction

  task automatic model_step();
    logic [7:0] b0, b1;
    int         j;
    if (!reset_L || !enable) begin
      k = 0;
      exp_q.delete();
    end else begin
      k++;
      if (k > PRE && ((k - PRE - 1) % 8) == 0) begin
        j  = (k - PRE - 1) / 8;
        b0 = valid_in_0 ? data_in_0 : COMMA;
        b1 = valid_in_1 ? data_in_1 : COMMA;
        if (slot_forced(j)) begin
          b0 = COMMA;
          b1 = COMMA;
        end
        exp_q.push_back({b1, b0});
      end
    end
  endtask

  initial forever begin
    @(posedge clk_8f or negedge reset_L);
    model_step();
  end

  // ---------------- scoreboard compare (every negedge) ----------------
  initial forever begin
    logic [7:0] comma_v;
    logic       e0, e1, er, ea;
    int         b;
    @(negedge clk_8f);
    comma_v = COMMA;
    e0 = 1'b0;
    e1 = 1'b0;
    if (k >= 1 && k <= PRE) begin
      e0 = comma_v[7 - ((k - 1) % 8)];
      e1 = e0;
    end else if (k > PRE) begin
      b = (k - PRE - 1) % 8;
      if (b == 0) begin
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else if (chk_en) check("model_queue_empty", 32'd0, 32'd1);
      end
      e0 = cur[7 - b];
      e1 = cur[15 - b];
    end
    er = enable && reset_L && (k >= PRE) && (((k - PRE) % 8) == 0) &&
         !slot_forced((k - PRE) / 8);
    ea = (k > PRE);
    if (chk_en) begin
      check("out_0", {31'd0, out_0}, {31'd0, e0});
      check("out_1", {31'd0, out_1}, {31'd0, e1});
      check("ready", {31'd0, ready}, {31'd0, er});
      check("tx_active", {31'd0, tx_active}, {31'd0, ea});
      check("dbg_state", {31'd0, dbg_state}, {31'd0, ea});
    end
  end

  // ---------------- driver tasks ----------------
  // Wait for ready, present one byte pair, collect the 8 bits that follow.
  task automatic send_byte(input logic [7:0] d0, input logic v0,
                           input logic [7:0] d1, input logic v1,
                           output logic [7:0] g0, output logic [7:0] g1);
    int w;
    w = 0;
    while (!ready && w < 40) begin
      @(negedge clk_8f);
      w++;
    end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
    data_in_0  = d0;
    valid_in_0 = v0;
    data_in_1  = d1;
    valid_in_1 = v1;
    g0 = 8'h00;
    g1 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_8f);
      g0 = {g0[6:0], out_0};
      g1 = {g1[6:0], out_1};
      // Inputs are don't-care away from the ready edge.
      data_in_0  = 8'($urandom_range(0, 255));
      data_in_1  = 8'($urandom_range(0, 255));
      valid_in_0 = 1'($urandom_range(0, 1));
      valid_in_1 = 1'($urandom_range(0, 1));
    end
  endtask

  // Count negedges after the next posedge until ready rises.
  task automatic cycles_to_ready(output int n);
    n = 0;
    @(posedge clk_8f);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_8f);
      if (ready && n == 0) n = i;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [31:0] pre0, pre1;
    logic [7:0]  g0, g1;
    int          first_ready, n;

    repeat (3) @(posedge clk_8f);
    @(negedge clk_8f);
    check("reset_out_0", {31'd0, out_0}, 32'd0);
    check("reset_out_1", {31'd0, out_1}, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_tx_active", {31'd0, tx_active}, 32'd0);
    chk_en = 1'b1;

    // Link bring-up: preamble of four commas per lane.
    @(posedge clk_8f); #2;
    reset_L = 1'b1;
    enable  = 1'b1;
    @(posedge clk_8f);
    pre0 = '0;
    pre1 = '0;
    first_ready = 0;
    for (int i = 1; i <= PRE; i++) begin
      @(negedge clk_8f);
      pre0 = {pre0[30:0], out_0};
      pre1 = {pre1[30:0], out_1};
      if (ready && first_ready == 0) first_ready = i;
    end
    check("preamble_lane0", pre0, 32'hBCBC_BCBC);
    check("preamble_lane1", pre1, 32'hBCBC_BCBC);
    check("first_ready_cycle", first_ready, 32'd32);
    check("tx_active_in_sync", {31'd0, tx_active}, 32'd0);

    send_byte(8'hFF, 1'b1, 8'h00, 1'b1, g0, g1);
    check("byte_ff_lane0", {24'd0, g0}, 32'hFF);
    check("byte_00_lane1", {24'd0, g1}, 32'h00);
    check("tx_active_after_sync", {31'd0, tx_active}, 32'd1);
    send_byte(8'hEE, 1'b1, 8'hDD, 1'b1, g0, g1);
    check("byte_ee_lane0", {24'd0, g0}, 32'hEE);
    check("byte_dd_lane1", {24'd0, g1}, 32'hDD);
    send_byte(8'h99, 1'b1, 8'h42, 1'b0, g0, g1);
    check("byte_99_lane0", {24'd0, g0}, 32'h99);
    check("invalid_lane1_comma", {24'd0, g1}, 32'hBC);
    check("tx_active_hold", {31'd0, tx_active}, 32'd1);

    // Drop enable with bit_cnt at 3, hold it low five cycles.
    data_in_0 = 8'hA5; valid_in_0 = 1'b1;
    data_in_1 = 8'h5A; valid_in_1 = 1'b1;
    repeat (4) @(posedge clk_8f);
    #2 enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_8f);
      @(negedge clk_8f);
      check("disabled_out_0", {31'd0, out_0}, 32'd0);
      check("disabled_out_1", {31'd0, out_1}, 32'd0);
      check("disabled_ready", {31'd0, ready}, 32'd0);
      check("disabled_tx_active", {31'd0, tx_active}, 32'd0);
    end
    @(posedge clk_8f); #2;
    enable = 1'b1;
    cycles_to_ready(n);
    check("reenable_ready_cycle", n, 32'd32);

    // Asynchronous reset mid-byte in ACTIVE.
    send_byte(8'h3C, 1'b1, 8'hC3, 1'b1, g0, g1);
    data_in_0 = 8'hF0; valid_in_0 = 1'b1;
    data_in_1 = 8'hFF; valid_in_1 = 1'b1;
    repeat (3) @(posedge clk_8f);
    #3 reset_L = 1'b0;
    #1;
    check("async_rst_out_0", {31'd0, out_0}, 32'd0);
    check("async_rst_out_1", {31'd0, out_1}, 32'd0);
    check("async_rst_ready", {31'd0, ready}, 32'd0);
    check("async_rst_tx_active", {31'd0, tx_active}, 32'd0);
    @(posedge clk_8f); #2;
    reset_L = 1'b1;
    cycles_to_ready(n);
    check("post_reset_ready_cycle", n, 32'd32);

    // Randomized traffic: long enabled stretch, then occasional drops.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk_8f); #2;
      data_in_0  = 8'($urandom_range(0, 255));
      data_in_1  = 8'($urandom_range(0, 255));
      valid_in_0 = ($urandom_range(0, 3) != 0);
      valid_in_1 = ($urandom_range(0, 3) != 0);
      if (c < 450) enable = 1'b1;
      else         enable = ($urandom_range(0, 149) != 0);
    end
    @(posedge clk_8f); #2;
    enable = 1'b1;
    repeat (2) @(negedge clk_8f);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
